// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: holds the program counter, fetches over a
// request/ready handshake with instruction memory and fills the IF/ID
// pipeline register. Redirects (taken branch/jump) arriving while a fetch
// is outstanding are remembered and applied when that fetch completes.
module busca_instrucao #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_pronto,
  input  logic [31:0] mem_dado,
  input  logic        stall,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  output logic [31:0] if_id_instrucao,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valido
);

  typedef enum logic {
    BUSCA  = 1'b0,
    SEGURA = 1'b1
  } estado_t;

  estado_t     estado_q;
  logic [31:0] pc_q;
  logic [31:0] buffer_q;
  logic        desvio_pendente_q;
  logic [31:0] alvo_pendente_q;
  logic [31:0] if_id_instrucao_q;
  logic [31:0] if_id_pc4_q;
  logic        if_id_valido_q;

  // Sequential address; wraps modulo 2^32.
  logic [31:0] pc_mais4_d;
  assign pc_mais4_d = pc_q + 32'd4;

  // Memory side: the address is the pc; a request is only issued while fetching.
  assign mem_endereco = pc_q;
  assign mem_req      = (estado_q == BUSCA) && !reset;

  assign if_id_instrucao = if_id_instrucao_q;
  assign if_id_pc4       = if_id_pc4_q;
  assign if_id_valido    = if_id_valido_q;

  // Fetch FSM together with the IF/ID register. IF/ID priority is
  // desvio (flush) > stall (hold) > delivery > bubble; a delivery only
  // happens with stall=0 and desvio=0, so the default bubble is overridden
  // in exactly those branches.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q          <= BUSCA;
      pc_q              <= PC_INICIAL;
      buffer_q          <= 32'd0;
      desvio_pendente_q <= 1'b0;
      alvo_pendente_q   <= 32'd0;
      if_id_instrucao_q <= 32'd0;
      if_id_pc4_q       <= 32'd0;
      if_id_valido_q    <= 1'b0;
    end else begin
      if (desvio) begin
        if_id_valido_q <= 1'b0;
      end else if (!stall) begin
        if_id_valido_q <= 1'b0;
      end

      case (estado_q)
        BUSCA: begin
          if (mem_pronto) begin
            if (desvio || desvio_pendente_q) begin
              // Fetched word belongs to the wrong path: drop it.
              pc_q              <= desvio ? alvo_desvio : alvo_pendente_q;
              desvio_pendente_q <= 1'b0;
            end else if (!stall) begin
              if_id_instrucao_q <= mem_dado;
              if_id_pc4_q       <= pc_mais4_d;
              if_id_valido_q    <= 1'b1;
              pc_q              <= pc_mais4_d;
            end else begin
              // Decode is busy: park the word and stop requesting.
              buffer_q <= mem_dado;
              pc_q     <= pc_mais4_d;
              estado_q <= SEGURA;
            end
          end else if (desvio) begin
            // Transaction cannot be aborted; remember the latest target.
            desvio_pendente_q <= 1'b1;
            alvo_pendente_q   <= alvo_desvio;
          end
        end
        SEGURA: begin
          if (desvio) begin
            pc_q     <= alvo_desvio;
            estado_q <= BUSCA;
          end else if (!stall) begin
            // pc already points past the buffered instruction.
            if_id_instrucao_q <= buffer_q;
            if_id_pc4_q       <= pc_q;
            if_id_valido_q    <= 1'b1;
            estado_q          <= BUSCA;
          end
        end
        default: estado_q <= BUSCA;
      endcase
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a table of per-cycle inputs and the
// outputs expected during that cycle, followed by a hand-written
// full-throughput sequence.
module tb_busca_instrucao;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_endereco;
  logic        mem_pronto;
  logic [31:0] mem_dado;
  logic        stall;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic [31:0] if_id_instrucao;
  logic [31:0] if_id_pc4;
  logic        if_id_valido;

  int n_vec;
  int n_err;

  busca_instrucao #(.PC_INICIAL(32'h0000_0000)) dut (
    .clock           (clock),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_endereco    (mem_endereco),
    .mem_pronto      (mem_pronto),
    .mem_dado        (mem_dado),
    .stall           (stall),
    .desvio          (desvio),
    .alvo_desvio     (alvo_desvio),
    .if_id_instrucao (if_id_instrucao),
    .if_id_pc4       (if_id_pc4),
    .if_id_valido    (if_id_valido)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents are derived from the address.
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign mem_dado = w(mem_endereco);

  typedef struct {
    logic        rst;
    logic        pr;
    logic        st;
    logic        ds;
    logic [31:0] alvo;
    logic        req;
    logic [31:0] ender;
    logic        vld;
    logic [31:0] pc4;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic pr, input logic st,
                     input logic ds, input logic [31:0] alvo,
                     input logic req, input logic [31:0] ender,
                     input logic vld, input logic [31:0] pc4,
                     input logic [31:0] ins);
    vec_t v;
    v.rst = rst; v.pr = pr; v.st = st; v.ds = ds; v.alvo = alvo;
    v.req = req; v.ender = ender; v.vld = vld; v.pc4 = pc4; v.ins = ins;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nome, input logic req, input logic [31:0] ender,
                     input logic vld, input logic [31:0] pc4, input logic [31:0] ins);
    n_vec++;
    if (mem_req !== req) begin
      n_err++;
      $display("FAIL %s mem_req got %b want %b", nome, mem_req, req);
    end
    if (mem_endereco !== ender) begin
      n_err++;
      $display("FAIL %s mem_endereco got %h want %h", nome, mem_endereco, ender);
    end
    if (if_id_valido !== vld) begin
      n_err++;
      $display("FAIL %s if_id_valido got %b want %b", nome, if_id_valido, vld);
    end
    if (if_id_pc4 !== pc4) begin
      n_err++;
      $display("FAIL %s if_id_pc4 got %h want %h", nome, if_id_pc4, pc4);
    end
    if (if_id_instrucao !== ins) begin
      n_err++;
      $display("FAIL %s if_id_instrucao got %h want %h", nome, if_id_instrucao, ins);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; mem_pronto = 1'b0; stall = 1'b0; desvio = 1'b0; alvo_desvio = 32'd0;

    //   rst pr st ds alvo           req ender          vld pc4            ins
    // reset, then full-rate fetch
    add(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h4,         1, 32'h4,         w(32'h0));
    // memory wait at 0x8 for 3 cycles
    add(0, 0, 0, 0, 32'h0,         1, 32'h8,         1, 32'h8,         w(32'h4));
    add(0, 0, 0, 0, 32'h0,         1, 32'h8,         0, 32'h8,         w(32'h4));
    add(0, 0, 0, 0, 32'h0,         1, 32'h8,         0, 32'h8,         w(32'h4));
    add(0, 1, 0, 0, 32'h0,         1, 32'h8,         0, 32'h8,         w(32'h4));
    add(0, 1, 0, 0, 32'h0,         1, 32'hC,         1, 32'hC,         w(32'h8));
    // stall for 3 cycles while fetching 0x10
    add(0, 1, 1, 0, 32'h0,         1, 32'h10,        1, 32'h10,        w(32'hC));
    add(0, 1, 1, 0, 32'h0,         0, 32'h14,        1, 32'h10,        w(32'hC));
    add(0, 1, 1, 0, 32'h0,         0, 32'h14,        1, 32'h10,        w(32'hC));
    add(0, 1, 0, 0, 32'h0,         0, 32'h14,        1, 32'h10,        w(32'hC));
    add(0, 1, 0, 0, 32'h0,         1, 32'h14,        1, 32'h14,        w(32'h10));
    // redirect to 0x40 in a ready cycle with stall=1
    add(0, 1, 1, 1, 32'h40,        1, 32'h18,        1, 32'h18,        w(32'h14));
    add(0, 1, 0, 0, 32'h0,         1, 32'h40,        0, 32'h18,        w(32'h14));
    // jump to 0x20, then two redirects while waiting there
    add(0, 1, 0, 1, 32'h20,        1, 32'h44,        1, 32'h44,        w(32'h40));
    add(0, 0, 0, 1, 32'h80,        1, 32'h20,        0, 32'h44,        w(32'h40));
    add(0, 0, 0, 1, 32'h90,        1, 32'h20,        0, 32'h44,        w(32'h40));
    add(0, 1, 0, 0, 32'h0,         1, 32'h20,        0, 32'h44,        w(32'h40));
    add(0, 1, 0, 0, 32'h0,         1, 32'h90,        0, 32'h44,        w(32'h40));
    // wrap-around at the top of the address space
    add(0, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h94,        1, 32'h94,        w(32'h90));
    add(0, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h94,        w(32'h90));
    add(0, 1, 0, 0, 32'h0,         1, 32'h0,         1, 32'h0,         w(32'hFFFF_FFFC));
    // reset while a fetch at 0x4 is outstanding; mem_pronto ignored
    add(0, 0, 0, 0, 32'h0,         1, 32'h4,         1, 32'h4,         w(32'h0));
    add(1, 1, 0, 0, 32'h0,         0, 32'h4,         0, 32'h4,         w(32'h0));
    add(0, 0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    // stall into SEGURA, then redirect drops the buffered word
    add(0, 1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    add(0, 0, 1, 1, 32'h200,       0, 32'h4,         0, 32'h0,         32'h0);
    add(0, 1, 0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0);
    add(0, 0, 0, 0, 32'h0,         1, 32'h204,       1, 32'h204,       w(32'h200));

    @(posedge clock);
    @(posedge clock);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset       = tbl[i].rst;
      mem_pronto  = tbl[i].pr;
      stall       = tbl[i].st;
      desvio      = tbl[i].ds;
      alvo_desvio = tbl[i].alvo;
      #1;
      chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].ender, tbl[i].vld,
          tbl[i].pc4, tbl[i].ins);
      @(posedge clock);
      #1;
    end

    // Hand-written: reset, then mem_pronto held high for 8 cycles.
    reset = 1'b1; mem_pronto = 1'b1; stall = 1'b0; desvio = 1'b0; alvo_desvio = 32'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k == 0)
        chk($sformatf("thr%0d", k), 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      else
        chk($sformatf("thr%0d", k), 1'b1, 32'(4 * k), 1'b1, 32'(4 * k),
            w(32'(4 * (k - 1))));
      @(posedge clock);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch stage of the simplified MIPS datapath. Holds the program counter and fetches over a request/ready handshake with instruction memory. Computes PC+4 internally and redirects to a branch/jump target supplied by the downstream stage. Fills the IF/ID pipeline register (instruction, PC+4, valid) consumed by decode, whose sign-extend/shift-by-2/adder path produces the branch target fed back here.

## Interface
- PC_INICIAL, 32'h0000_0000, PC value loaded on reset
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- mem_req  output  1  instruction memory request
- mem_endereco  output  32  fetch address; equals current pc
- mem_pronto  input  1  memory has valid data on mem_dado this cycle
- mem_dado  input  32  fetched instruction word
- stall  input  1  decode cannot accept; hold IF/ID
- desvio  input  1  redirect request (taken branch/jump); also flushes IF/ID
- alvo_desvio  input  32  redirect target address
- if_id_instrucao  output  32  registered instruction to decode
- if_id_pc4  output  32  registered PC+4 of that instruction
- if_id_valido  output  1  IF/ID holds a real instruction

## Operation
- Registers: pc, estado {BUSCA, SEGURA}, buffer (32b), desvio_pendente, alvo_pendente (32b), IF/ID triple.
- mem_endereco = pc always. mem_req = 1 iff estado==BUSCA and reset==0.
- Handshake: once mem_req is high, pc/mem_endereco stay constant until a cycle with mem_pronto=1. Transactions are never aborted.
- BUSCA, mem_pronto=0: stay. If desvio=1, set desvio_pendente=1 and alvo_pendente=alvo_desvio. A later desvio overwrites alvo_pendente.
- BUSCA, mem_pronto=1, with desvio=1 or desvio_pendente=1: discard mem_dado. pc <= alvo_desvio if desvio=1, else alvo_pendente. Clear desvio_pendente. Stay BUSCA.
- BUSCA, mem_pronto=1, no redirect, stall=0: IF/ID <= {mem_dado, pc+4, 1}. pc <= pc+4. Stay BUSCA.
- BUSCA, mem_pronto=1, no redirect, stall=1: buffer <= mem_dado. pc <= pc+4. Go SEGURA; IF/ID unchanged.
- SEGURA: mem_req=0.
  - desvio=1: drop buffer, pc <= alvo_desvio, go BUSCA.
  - stall=0: IF/ID <= {buffer, pc, 1}, where pc already equals PC+4 of the buffered instruction. Go BUSCA.
  - Otherwise hold.
- IF/ID rules, evaluated each edge in priority order:
  - desvio=1: if_id_valido <= 0; instruction/pc4 unchanged.
  - stall=1: hold all three.
  - A new instruction is delivered (above): load it.
  - Otherwise: if_id_valido <= 0 (bubble).
- Priority: reset > desvio > stall > normal fetch.
- PC arithmetic is modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0. Alignment is not checked.

## Timing
- Reset (edge with reset=1):
  - pc=PC_INICIAL, estado=BUSCA, desvio_pendente=0, buffer=0, alvo_pendente=0.
  - if_id_instrucao=0, if_id_pc4=0, if_id_valido=0.
  - mem_req=0 while reset is high. mem_endereco=PC_INICIAL.
- Reset mid-transaction: the outstanding fetch is abandoned. The memory must tolerate the dropped request; its mem_pronto in the reset cycle is ignored.
- First request: the cycle after reset deasserts.
- Latency: mem_pronto in cycle N makes the instruction visible on IF/ID in cycle N+1.
- Throughput: with mem_pronto tied high, one instruction per cycle; pc advances by 4 every cycle.
- Redirect: desvio in cycle N (with mem_pronto=1, or in SEGURA) puts the new pc on mem_endereco in cycle N+1, with if_id_valido=0 in N+1.
- Redirect while waiting on memory: the new address is issued the cycle after that transaction's mem_pronto.
- Stall release from SEGURA: IF/ID loads on the edge ending the stall=0 cycle. The next request starts the following cycle, giving one bubble.

## Test plan
- Reset, mem_pronto=1, mem_dado=pc-derived, PC_INICIAL=0 -> mem_endereco 0,4,8,… on consecutive cycles; if_id_pc4 = 4,8,12 one cycle later; if_id_valido=1 from cycle 2.
- mem_pronto delayed 3 cycles at address 8 -> mem_req high and mem_endereco=8 for all 4 cycles; if_id_valido=0 meanwhile; then if_id_pc4=12.
- stall=1 for 3 cycles during fetch of 0x10 -> IF/ID frozen; mem_req=0 in SEGURA; on release if_id_instrucao=word@0x10, if_id_pc4=0x14; next request at 0x14.
- desvio=1, alvo_desvio=0x40, in a mem_pronto cycle with stall=1 -> data discarded; if_id_valido=0; next mem_endereco=0x40.
- desvio (alvo 0x80) during a wait at 0x20, then desvio (alvo 0x90), then mem_pronto -> word@0x20 never reaches IF/ID; next request at 0x90.
- pc=32'hFFFF_FFFC fetched -> if_id_pc4=0; next mem_endereco=0. Reset asserted mid-wait -> all reset values next cycle.
